ins_memory: RTL and testbench
=============================

Name: ins_memory

Overview:
- Instruction memory for the single-cycle CPU; the PC drives IAddr, and IDataOut feeds the instruction decoder.
- Byte-addressed, big-endian store of 32-bit words.
- Reads are combinational; writes are clocked and used for program loading.
- Asynchronous active-low reset clears the whole array.

Parameters:
- DEPTH_BYTES, 256: storage size in bytes; must be a power of two and at least 4.
- AW, 8: number of address bits actually decoded; equals log2(DEPTH_BYTES).

Ports:
- CLK  input  1  system clock; writes occur on its rising edge.
- Reset  input  1  asynchronous, active-low; clears memory.
- IAddr  input  32  byte address of the instruction word.
- IDataIn  input  32  word to store when RW=1.
- RW  input  1  0 = read only, 1 = write IDataIn at IAddr on the next rising CLK edge.
- IDataOut  output  32  instruction word at IAddr.

Behaviour:
- Interface: one clock (CLK); Reset is asynchronous and active-low.
- Storage: DEPTH_BYTES bytes, mem[0..DEPTH_BYTES-1].
- Word alignment: IAddr[1:0] is ignored. The effective base is B = {IAddr[31:2], 2'b00}.
- Read (combinational, zero-cycle latency), big-endian:
  - IDataOut = {mem[B], mem[B+1], mem[B+2], mem[B+3]}.
  - Output follows IAddr and memory contents continuously, independent of RW.
- Out of range: if IAddr[31:AW] != 0, IDataOut = 32'h0000_0000.
- Write:
  - On a rising CLK edge with Reset=1, RW=1 and IAddr in range:
    - mem[B] <= IDataIn[31:24], mem[B+1] <= IDataIn[23:16], mem[B+2] <= IDataIn[15:8], mem[B+3] <= IDataIn[7:0].
  - Out-of-range writes are silently dropped.
  - RW=0 never modifies memory.
- Read-during-write at the same address: IDataOut shows old data before the edge and new data after it (same delta-settled cycle).
- Reset:
  - While Reset=0, every byte is forced to 0 immediately, without waiting for CLK, so IDataOut = 0.
  - Writes are blocked while Reset=0.
  - Reset asserted mid-write cycle: the write is lost and memory is zero.
  - After Reset deasserts, the first write takes effect on the next rising CLK edge.
- No X on IDataOut after reset, for any IAddr value.
- Output reset value: IDataOut = 0 for all addresses while Reset=0 and after reset until written.

Test Plan:
- Reset: hold Reset=0, sweep IAddr = 0, 4, 8, 252 -> IDataOut = 32'h0 each; release Reset -> still 0.
- Write then read:
  - Reset=1, RW=1, IAddr=0, IDataIn=32'h0800_0004 then IAddr=4, IDataIn=32'h2001_0008 then IAddr=8, IDataIn=32'hAC22_0000, one CLK edge each.
  - Set RW=0 and read IAddr=0, 4, 8 -> 32'h0800_0004, 32'h2001_0008, 32'hAC22_0000.
- Byte order and alignment:
  - Write 32'h1122_3344 at IAddr=12.
  - Read IAddr=12 -> 32'h1122_3344.
  - Read IAddr=13, 14, 15 -> 32'h1122_3344 (low bits ignored).
- Out of range and RW gating:
  - Write 32'hDEAD_BEEF at IAddr=256 with RW=1 -> IDataOut at 256 = 0 and word 0 unchanged.
  - RW=0 with IDataIn=32'hFFFF_FFFF at IAddr=4 -> 32'h2001_0008 retained.
- Async reset mid-operation:
  - With memory loaded, drop Reset between CLK edges -> IDataOut becomes 0 without a clock edge.
  - A write attempted with Reset=0 -> still 0 after release.
- Read-during-write: IAddr=20, RW=1, IDataIn=32'hCAFE_F00D -> IDataOut = 0 before the edge, 32'hCAFE_F00D right after it.

Source files
------------

// File: rtl/ins_memory.sv
// Byte-addressed big-endian instruction memory.
// Combinational word read, clocked word write, async clear.
module ins_memory #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned AW          = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] IAddr,
  input  logic [31:0] IDataIn,
  input  logic        RW,
  output logic [31:0] IDataOut
);

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic          in_range;
  logic          we;
  logic [AW-1:0] b0;
  logic [AW-1:0] b1;
  logic [AW-1:0] b2;
  logic [AW-1:0] b3;
  logic          unused_low;

  // Byte-lane indices of the aligned word; low address bits are dropped.
  always_comb begin
    in_range = (IAddr[31:AW] == '0);
    we       = RW & in_range;
    b0       = {IAddr[AW-1:2], 2'b00};
    b1       = {IAddr[AW-1:2], 2'b01};
    b2       = {IAddr[AW-1:2], 2'b10};
    b3       = {IAddr[AW-1:2], 2'b11};
  end

  assign unused_low = ^IAddr[1:0];

  // Storage: cleared asynchronously, written a word at a time.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[b0] <= IDataIn[31:24];
      mem_q[b1] <= IDataIn[23:16];
      mem_q[b2] <= IDataIn[15:8];
      mem_q[b3] <= IDataIn[7:0];
    end
  end

  // Big-endian word read; out-of-range addresses read as zero.
  always_comb begin
    IDataOut = '0;
    if (in_range) begin
      IDataOut = {mem_q[b0], mem_q[b1], mem_q[b2], mem_q[b3]};
    end
  end

endmodule

// File: tb/tb_ins_memory.sv
// Self-checking bench for ins_memory.
// Expected words are queued at stimulus time and popped at check time.
module tb_ins_memory;

  logic        CLK;
  logic        Reset;
  logic [31:0] IAddr;
  logic [31:0] IDataIn;
  logic        RW;
  logic [31:0] IDataOut;

  int          n_tests;
  int          n_fails;
  logic [31:0] exp_q [$];
  logic [31:0] exp;

  ins_memory #(
    .DEPTH_BYTES(256),
    .AW(8)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .IAddr(IAddr),
    .IDataIn(IDataIn),
    .RW(RW),
    .IDataOut(IDataOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    IAddr   = a;
    IDataIn = d;
    RW      = 1'b1;
    @(posedge CLK);
    #1;
    RW = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [4];
    addrs = '{32'd0, 32'd4, 32'd8, 32'd252};
    Reset = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      IAddr = addrs[i];
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (IDataOut !== exp) begin
        n_fails++;
        $display("FAIL reset_hold a=%0d got=%h exp=%h", addrs[i], IDataOut, exp);
      end
    end
    @(negedge CLK);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      IAddr = addrs[i];
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (IDataOut !== exp) begin
        n_fails++;
        $display("FAIL reset_release a=%0d got=%h exp=%h", addrs[i], IDataOut, exp);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] a [3];
    logic [31:0] d [3];
    a = '{32'd0, 32'd4, 32'd8};
    d = '{32'h0800_0004, 32'h2001_0008, 32'hAC22_0000};
    for (int i = 0; i < 3; i++) begin
      wr(a[i], d[i]);
      exp_q.push_back(d[i]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      IAddr = a[i];
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (IDataOut !== exp) begin
        n_fails++;
        $display("FAIL write_read a=%0d got=%h exp=%h", a[i], IDataOut, exp);
      end
    end
  endtask

  task automatic test_alignment();
    wr(32'd12, 32'h1122_3344);
    for (int i = 12; i < 16; i++) begin
      exp_q.push_back(32'h1122_3344);
      IAddr = i;
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (IDataOut !== exp) begin
        n_fails++;
        $display("FAIL align a=%0d got=%h exp=%h", i, IDataOut, exp);
      end
    end
    wr(32'd16, 32'hA1B2_C3D4);
    exp_q.push_back(32'h1122_3344);
    IAddr = 32'd12;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL align_neighbor got=%h exp=%h", IDataOut, exp);
    end
  endtask

  task automatic test_out_of_range();
    wr(32'd256, 32'hDEAD_BEEF);
    exp_q.push_back(32'h0);
    IAddr = 32'd256;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL oor_read got=%h exp=%h", IDataOut, exp);
    end
    exp_q.push_back(32'h0800_0004);
    IAddr = 32'd0;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL oor_alias got=%h exp=%h", IDataOut, exp);
    end
    exp_q.push_back(32'h0);
    IAddr = 32'h8000_0004;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL oor_high got=%h exp=%h", IDataOut, exp);
    end
    @(negedge CLK);
    IAddr   = 32'd4;
    IDataIn = 32'hFFFF_FFFF;
    RW      = 1'b0;
    exp_q.push_back(32'h2001_0008);
    @(posedge CLK);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL rw_gate got=%h exp=%h", IDataOut, exp);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    IAddr = 32'd4;
    #2;
    Reset = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL async_clear got=%h exp=%h", IDataOut, exp);
    end
    @(negedge CLK);
    IAddr   = 32'd24;
    IDataIn = 32'h5555_AAAA;
    RW      = 1'b1;
    @(posedge CLK);
    #1;
    RW = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL write_in_reset got=%h exp=%h", IDataOut, exp);
    end
    exp_q.push_back(32'h0);
    IAddr = 32'd8;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL cleared_word8 got=%h exp=%h", IDataOut, exp);
    end
  endtask

  task automatic test_rdw();
    @(negedge CLK);
    IAddr   = 32'd20;
    IDataIn = 32'hCAFE_F00D;
    RW      = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL rdw_before got=%h exp=%h", IDataOut, exp);
    end
    @(posedge CLK);
    #1;
    RW = 1'b0;
    exp = exp_q.pop_front();
    n_tests++;
    if (IDataOut !== exp) begin
      n_fails++;
      $display("FAIL rdw_after got=%h exp=%h", IDataOut, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      wr(32'(128 + 4 * i), d);
      exp_q.push_back(d);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      IAddr = 32'(128 + 4 * i + (i % 4));
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (IDataOut !== exp) begin
        n_fails++;
        $display("FAIL b2b a=%0d got=%h exp=%h", IAddr, IDataOut, exp);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fails = 0;
    Reset   = 1'b1;
    IAddr   = '0;
    IDataIn = '0;
    RW      = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_alignment();
    test_out_of_range();
    test_async_reset();
    test_rdw();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
